// File: rtl/radix4_seq_multiplier_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_pkg : shared types and helpers for radix4_seq_multiplier        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  // A single-digit operand still needs one counter bit.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_seq_multiplier_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_seq_multiplier_if : operand/product valid-ready bundle       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface radix4_seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface
`default_nettype wire

// File: rtl/radix4_seq_multiplier_scaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_digit_scaler : combinational x * d for d in 0..3            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module radix4_digit_scaler #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       d,
  output logic [WIDTH+1:0] y
);

  logic [WIDTH+1:0] w_x1;
  logic [WIDTH+1:0] w_x2;

  assign w_x1 = (WIDTH+2)'(x);
  assign w_x2 = w_x1 << 1;

  always_comb begin
    y = '0;
    case (d)
      2'd0: y = '0;
      2'd1: y = w_x1;
      2'd2: y = w_x2;
      2'd3: y = w_x2 + w_x1;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/radix4_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_seq_multiplier : unsigned a*b, one radix-4 digit per cycle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module radix4_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  radix4_seq_multiplier_if.slave       bus
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0] c_last_k = CNT_W'(DIGITS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [CNT_W-1:0]     r_k;

  logic [DIGIT_W-1:0]   w_d;
  logic [WIDTH+1:0]     w_y;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_busy;

  assign w_d       = r_b[{r_k, 1'b0} +: DIGIT_W];
  assign w_pp      = (2*WIDTH)'(w_y) << {r_k, 1'b0};
  assign w_acc_nxt = r_acc + w_pp;
  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_last    = (r_k == c_last_k);

  radix4_digit_scaler #(
    .WIDTH (WIDTH)
  ) u_scaler (
    .x (r_a),
    .d (w_d),
    .y (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.in_valid)  w_state_nxt = RUN;
      RUN:  if (w_last)        w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // in_ready is held low while reset is asserted so nothing is offered mid-reset.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: w_in_ready  = ~rst;
      RUN:  w_busy      = 1'b1;
      DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_acc <= '0;
      r_k   <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_k   <= r_k + 1'b1;
      if (w_last) begin
        r_product <= w_acc_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.product   = r_product;

endmodule
`default_nettype wire
